// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the operand-forwarding stage.
// Select encoding: 0 = register file, s+1 = producer stage s.
package fwd_pkg;

    localparam int SEL_RF = 0;

    function automatic int sel_w(input int nsrc);
        return $clog2(nsrc + 1);
    endfunction

    // Low bit of element idx in a flat vector of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/fwd_prio_match.sv
// Priority match of one operand address against all in-flight producers.
// The youngest matching producer wins; register 0 always reads the register file.
module fwd_prio_match
    import fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NSRC   = 3,
    localparam int SEL_W = sel_w(NSRC)
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      rf_data,
    input  logic [NSRC-1:0]        st_wen,
    input  logic [NSRC*ADDR_W-1:0] st_addr,
    input  logic [NSRC*DATA_W-1:0] st_data,
    input  logic [NSRC-1:0]        st_dvld,
    output logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      data,
    output logic                   blocked
);

    logic found;

    // A blocked younger match stops the search, so an older ready copy never leaks through.
    always_comb begin
        sel     = SEL_W'(SEL_RF);
        data    = rf_data;
        blocked = 1'b0;
        found   = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (!found && st_wen[s] && (addr != '0) &&
                (st_addr[slice_lo(s, ADDR_W) +: ADDR_W] == addr)) begin
                found   = 1'b1;
                sel     = SEL_W'(s + 1);
                data    = st_data[slice_lo(s, DATA_W) +: DATA_W];
                blocked = !st_dvld[s];
            end
        end
    end

endmodule

// File: rtl/fwd_bypass_stage.sv
// Decode-side operand forwarding with hazard stall, registered valid/ready output,
// flush and a saturating stall counter.
module fwd_bypass_stage
    import fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NSRC   = 3,
    parameter int NOPER  = 2,
    parameter int CNT_W  = 16,
    localparam int SEL_W = sel_w(NSRC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NOPER*ADDR_W-1:0] in_addr,
    input  logic [NOPER*DATA_W-1:0] in_rf_data,
    input  logic [NSRC-1:0]         st_wen,
    input  logic [NSRC*ADDR_W-1:0]  st_addr,
    input  logic [NSRC*DATA_W-1:0]  st_data,
    input  logic [NSRC-1:0]         st_dvld,
    output logic                    hazard,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NOPER*DATA_W-1:0] out_data,
    output logic [NOPER*SEL_W-1:0]  out_sel,
    output logic [CNT_W-1:0]        stall_cnt,
    input  logic                    stall_clr
);

    logic [NOPER*DATA_W-1:0] fwd_data;
    logic [NOPER*SEL_W-1:0]  fwd_sel;
    logic [NOPER-1:0]        blocked;
    logic                    accept;

    for (genvar k = 0; k < NOPER; k++) begin : g_oper
        fwd_prio_match #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W),
            .NSRC  (NSRC)
        ) u_match (
            .addr   (in_addr[slice_lo(k, ADDR_W) +: ADDR_W]),
            .rf_data(in_rf_data[slice_lo(k, DATA_W) +: DATA_W]),
            .st_wen (st_wen),
            .st_addr(st_addr),
            .st_data(st_data),
            .st_dvld(st_dvld),
            .sel    (fwd_sel[slice_lo(k, SEL_W) +: SEL_W]),
            .data   (fwd_data[slice_lo(k, DATA_W) +: DATA_W]),
            .blocked(blocked[k])
        );
    end

    assign hazard   = in_valid && (|blocked);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !hazard && !flush;

    // Flush only drops the valid bit; data and select keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= fwd_data;
            out_sel   <= fwd_sel;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_bypass_stage.sv
// Directed scoreboard bench for fwd_bypass_stage (NSRC=3, NOPER=2, CNT_W=2).
module tb_fwd_bypass_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NSRC   = 3;
    localparam int NOPER  = 2;
    localparam int CNT_W  = 2;
    localparam int SEL_W  = 2;

    typedef struct {
        logic [NOPER*DATA_W-1:0] data;
        logic [NOPER*SEL_W-1:0]  sel;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [NOPER*ADDR_W-1:0] in_addr;
    logic [NOPER*DATA_W-1:0] in_rf_data;
    logic [NSRC-1:0]         st_wen;
    logic [NSRC*ADDR_W-1:0]  st_addr;
    logic [NSRC*DATA_W-1:0]  st_data;
    logic [NSRC-1:0]         st_dvld;
    logic                    hazard;
    logic                    out_valid;
    logic                    out_ready;
    logic [NOPER*DATA_W-1:0] out_data;
    logic [NOPER*SEL_W-1:0]  out_sel;
    logic [CNT_W-1:0]        stall_cnt;
    logic                    stall_clr;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];

    fwd_bypass_stage #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NSRC  (NSRC),
        .NOPER (NOPER),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_rf_data(in_rf_data),
        .st_wen    (st_wen),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_dvld   (st_dvld),
        .hazard    (hazard),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a0,
                                 input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r0,
                                 input logic [NSRC-1:0] wen, input logic [NSRC*ADDR_W-1:0] saddr,
                                 input logic [NSRC*DATA_W-1:0] sdata, input logic [NSRC-1:0] dvld);
        in_valid   = v;
        in_addr    = {a1, a0};
        in_rf_data = {r1, r0};
        st_wen     = wen;
        st_addr    = saddr;
        st_data    = sdata;
        st_dvld    = dvld;
    endtask

    task automatic expectAccept(input logic [NOPER*DATA_W-1:0] d, input logic [NOPER*SEL_W-1:0] s);
        exp_t e;
        e.data = d;
        e.sel  = s;
        sbq.push_back(e);
    endtask

    task automatic checkScoreboard(input string tag);
        exp_t e;
        checkOutput({tag, "_sb_nonempty"}, 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
            checkOutput({tag, "_data"}, out_data, e.data);
            checkOutput({tag, "_sel"}, 64'(out_sel), 64'(e.sel));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        stall_clr = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 3'b000, '0, '0, 3'b000);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_out_sel", 64'(out_sel), 64'd0);
        checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("[TB] no-match forwarding");
        applyStimulus(1'b1, 5'd3, 5'd5, 32'h22, 32'h11, 3'b000, '0, '0, 3'b000);
        #1;
        checkOutput("nomatch_hazard", 64'(hazard), 64'd0);
        expectAccept({32'h22, 32'h11}, 4'b0000);
        tick();
        checkScoreboard("nomatch");

        $display("[TB] priority and register 0");
        applyStimulus(1'b1, 5'd2, 5'd8, 32'h77, 32'h0, 3'b111, {5'd8, 5'd8, 5'd8},
                      {32'hC, 32'hB, 32'hA}, 3'b111);
        expectAccept({32'h77, 32'hA}, 4'b0001);
        tick();
        checkScoreboard("prio");
        applyStimulus(1'b1, 5'd0, 5'd0, 32'h44, 32'h33, 3'b111, {5'd0, 5'd0, 5'd0},
                      {32'hC, 32'hB, 32'hA}, 3'b111);
        expectAccept({32'h44, 32'h33}, 4'b0000);
        tick();
        checkScoreboard("reg0");

        $display("[TB] load-use hazard");
        applyStimulus(1'b1, 5'd1, 5'd4, 32'h66, 32'h0, 3'b011, {5'd8, 5'd4, 5'd4},
                      {32'hC, 32'hBB, 32'hDD}, 3'b110);
        #1;
        checkOutput("ld_hazard", 64'(hazard), 64'd1);
        tick();
        checkOutput("ld_valid_1", 64'(out_valid), 64'd0);
        checkOutput("ld_cnt_1", 64'(stall_cnt), 64'd1);
        tick();
        checkOutput("ld_valid_2", 64'(out_valid), 64'd0);
        checkOutput("ld_cnt_2", 64'(stall_cnt), 64'd2);
        applyStimulus(1'b1, 5'd1, 5'd4, 32'h66, 32'h0, 3'b011, {5'd8, 5'd4, 5'd4},
                      {32'hC, 32'hBB, 32'h55}, 3'b111);
        #1;
        checkOutput("ld_hazard_clear", 64'(hazard), 64'd0);
        expectAccept({32'h66, 32'h55}, 4'b0001);
        tick();
        checkScoreboard("ld_accept");
        checkOutput("ld_cnt_hold", 64'(stall_cnt), 64'd2);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(1'b1, 5'd3, 5'd5, 32'h88, 32'h99, 3'b000, '0, '0, 3'b000);
        #1;
        checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_data", out_data, {32'h66, 32'h55});
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_release", 64'(in_ready), 64'd1);
        expectAccept({32'h88, 32'h99}, 4'b0000);
        tick();
        checkScoreboard("bp_release");

        $display("[TB] flush and async reset");
        flush = 1'b1;
        applyStimulus(1'b1, 5'd3, 5'd5, 32'h2, 32'h1, 3'b000, '0, '0, 3'b000);
        tick();
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        applyStimulus(1'b1, 5'd3, 5'd5, 32'h4, 32'h3, 3'b000, '0, '0, 3'b000);
        expectAccept({32'h4, 32'h3}, 4'b0000);
        tick();
        checkScoreboard("pre_rst");
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", 64'(out_valid), 64'd0);
        checkOutput("arst_data", out_data, 64'd0);
        checkOutput("arst_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("[TB] stall counter saturation");
        applyStimulus(1'b1, 5'd0, 5'd4, 32'h0, 32'h0, 3'b001, {5'd0, 5'd0, 5'd4},
                      {32'h0, 32'h0, 32'h1}, 3'b000);
        for (int i = 1; i <= 5; i++) begin
            tick();
            checkOutput("sat_cnt", 64'(stall_cnt), 64'((i > 3) ? 3 : i));
        end
        stall_clr = 1'b1;
        #1;
        checkOutput("clr_hazard", 64'(hazard), 64'd1);
        tick();
        checkOutput("clr_cnt", 64'(stall_cnt), 64'd0);
        stall_clr = 1'b0;
        in_valid  = 1'b0;
        #1;
        checkOutput("novalid_hazard", 64'(hazard), 64'd0);
        tick();
        checkOutput("idle_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("idle_valid", 64'(out_valid), 64'd0);

        checkOutput("sb_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_bypass_stage.md
# fwd_bypass_stage

Parametrised operand-forwarding stage for the decode side of the pipeline. For each of NOPER source operands it resolves a bypass select from NSRC in-flight producer stages, with the register file as fallback. It detects not-yet-available producer data (e.g. load in E) and holds the instruction, and it registers the forwarded operands behind a valid/ready handshake. It replaces the fixed 4:1 decode forwarding mux and adds hazard stalling, flush and a stall counter.

## Interface
- DATA_W, 32, operand/data width
- ADDR_W, 5, register address width
- NSRC, 3, number of forwarding sources; index 0 = youngest (E), NSRC-1 = oldest (W)
- NOPER, 2, operands per instruction
- CNT_W, 16, stall counter width
- SEL_W is derived as $clog2(NSRC+1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous flush of output register
- in_valid  in  1  decode operands present
- in_ready  out  1  stage can accept (combinational)
- in_addr  in  NOPER*ADDR_W  operand register addresses, operand k at [k*ADDR_W +: ADDR_W]
- in_rf_data  in  NOPER*DATA_W  register-file read data per operand
- st_wen  in  NSRC  source s will write a register
- st_addr  in  NSRC*ADDR_W  destination address per source
- st_data  in  NSRC*DATA_W  result data per source
- st_dvld  in  NSRC  source s data is already available
- hazard  out  1  combinational: in_valid and some operand waits on unavailable data
- out_valid  out  1  registered operands valid
- out_ready  in  1  consumer accepts
- out_data  out  NOPER*DATA_W  registered forwarded operands
- out_sel  out  NOPER*SEL_W  registered select per operand: 0 = RF, s+1 = source s
- stall_cnt  out  CNT_W  saturating count of hazard cycles
- stall_clr  in  1  synchronous clear of stall_cnt

## Operation
- Per operand k, match[s] = st_wen[s] & (st_addr[s] == addr_k) & (addr_k != 0).
- Select is the lowest s with match[s], i.e. the youngest source. If none matches, the RF is used. Register 0 is never forwarded and always reads in_rf_data.
- Operand k is blocked when its selected source has st_dvld=0. Older matches never override a blocked younger match.
- hazard = in_valid & (any operand blocked).
- in_ready = !out_valid | out_ready.
- accept = in_valid & in_ready & !hazard & !flush.
- On accept, out_data, out_sel and out_valid=1 load next edge.
- Else if out_valid & out_ready, out_valid clears.
- flush clears out_valid and has priority over accept and hold.
- Under backpressure (out_valid & !out_ready), the output register holds its value. Selection is recomputed every cycle from current inputs. Nothing is latched while stalled.
- stall_cnt increments on each cycle with hazard=1 and saturates at 2^CNT_W-1.
- stall_clr wins over increment (value 0 next cycle).

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, stall_cnt=0. hazard and in_ready follow their combinational inputs.
- Latency: accept at edge N gives out_valid/out_data from edge N through N+1.
- Full throughput is one instruction per cycle when out_ready=1 and hazard=0.
- Simultaneous accept and drain (out_valid & out_ready & accept): the new data replaces the old, and out_valid stays 1.
- Reset asserted mid-transfer: all registers clear immediately, without waiting for clk. The accepted data is lost.
- Hazard with st_dvld rising in cycle N: accept occurs at edge N.

## Structure
- Package fwd_pkg holds:
  - SEL_RF = 0
  - function sel_w(nsrc)
  - per-operand slice helper functions
- Sub-module fwd_prio_match, instantiated NOPER times. It is purely combinational. It takes one address plus the st_* vectors and returns the select index, the forwarded data and the blocked flag.
- The top level holds the handshake register, flush logic and stall counter.

## Test plan
- No match: in_addr={5,3}, no st_wen, rf={0x11,0x22} -> next cycle out_data={0x11,0x22}, out_sel={0,0}.
- Priority: operand 0 addr=8; st_wen=3'b111, all st_addr=8, st_data={0xC,0xB,0xA} (source 0 = 0xA), all dvld -> out_data[0]=0xA, out_sel[0]=1. Also drive addr=0 with all sources matching 0 -> RF data, sel=0.
- Load-use: source 0 addr=4, dvld=0, operand addr=4 -> hazard=1, out_valid stays 0, and stall_cnt counts 1,2. Then dvld=1 with data 0x55 -> accept, out_data=0x55.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, out_data unchanged. Then out_ready=1 -> new data is loaded the same edge the old data drains.
- Flush and reset: flush on an accept cycle -> out_valid=0. Async rst mid-stream -> outputs 0 before the next edge.
- Counter: CNT_W=2 with 5 hazard cycles -> stall_cnt saturates at 3. stall_clr together with hazard -> 0.
